// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Captures the winning request, drives the ALU for one cycle, returns a registered result.
module alu_arbiter #(
   parameter int unsigned DW  = 32,
   parameter int unsigned OPW = 4
) (
   input  logic           CLK,
   input  logic           nRST,
   input  logic           req0,
   input  logic           req1,
   input  logic [DW-1:0]  op1_0,
   input  logic [DW-1:0]  op2_0,
   input  logic [DW-1:0]  op1_1,
   input  logic [DW-1:0]  op2_1,
   input  logic [OPW-1:0] opc0,
   input  logic [OPW-1:0] opc1,
   output logic           ack0,
   output logic           ack1,
   output logic           done0,
   output logic           done1,
   output logic [DW-1:0]  res_out,
   output logic           z_out,
   output logic           n_out,
   output logic           v_out,
   output logic           busy,
   output logic [DW-1:0]  alu_op1,
   output logic [DW-1:0]  alu_op2,
   output logic [OPW-1:0] alu_opcode,
   input  logic [DW-1:0]  alu_res,
   input  logic           alu_z,
   input  logic           alu_n,
   input  logic           alu_v
);

   localparam int unsigned SW = 2;
   localparam logic [SW-1:0] S_IDLE = 2'd0;
   localparam logic [SW-1:0] S_EXEC = 2'd1;
   localparam logic [SW-1:0] S_RESP = 2'd2;

   logic [SW-1:0]  state;
   logic [SW-1:0]  state_nxt;
   logic           can_accept;
   logic           grant0;
   logic           grant1;
   logic           last;
   logic           win_id;
   logic [DW-1:0]  op1_q;
   logic [DW-1:0]  op2_q;
   logic [OPW-1:0] opc_q;

   // State register
   always_ff @(posedge CLK) begin
      if (!nRST) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next state and round-robin grant; a tie goes to the requester that did not win last
   always_comb begin
      state_nxt  = state;
      can_accept = 1'b0;
      grant0     = 1'b0;
      grant1     = 1'b0;
      case (state)
         S_IDLE: can_accept = 1'b1;
         S_EXEC: state_nxt  = S_RESP;
         S_RESP: begin
            can_accept = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (can_accept && nRST) begin
         grant0 = req0 & (~req1 | last);
         grant1 = req1 & (~req0 | ~last);
         if (grant0 || grant1) state_nxt = S_EXEC;
      end
   end

   assign ack0       = grant0;
   assign ack1       = grant1;
   assign alu_op1    = op1_q;
   assign alu_op2    = op2_q;
   assign alu_opcode = opc_q;

   // Request capture, result capture and done pulses
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         last    <= 1'b1;
         win_id  <= 1'b0;
         op1_q   <= '0;
         op2_q   <= '0;
         opc_q   <= '0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         res_out <= '0;
         z_out   <= 1'b0;
         n_out   <= 1'b0;
         v_out   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         done0 <= (state == S_EXEC) && !win_id;
         done1 <= (state == S_EXEC) && win_id;
         busy  <= (state_nxt == S_EXEC);
         if (state == S_EXEC) begin
            res_out <= alu_res;
            z_out   <= alu_z;
            n_out   <= alu_n;
            v_out   <= alu_v;
         end
         if (grant0) begin
            op1_q  <= op1_0;
            op2_q  <= op2_0;
            opc_q  <= opc0;
            win_id <= 1'b0;
            last   <= 1'b0;
         end else if (grant1) begin
            op1_q  <= op1_1;
            op2_q  <= op2_1;
            opc_q  <= opc1;
            win_id <= 1'b1;
            last   <= 1'b1;
         end
      end
   end

endmodule
